pipeline_hazard_ctrl: RTL and testbench



---
 rtl/hazard_pkg.sv | 29 ++
 rtl/hazard_detect.sv | 38 +++
 rtl/pipeline_hazard_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// ---------------------------------------------------------------------------
// hazard_pkg
// Shared types and constants for the pipeline hazard controller and the
// load-use comparator (also reused by the forwarding unit).
//   ST_*          : encodings of the controller FSM, also reported on ctrl_state
//   ctrl_state_t  : enum view of the same encodings
//   REG_ZERO      : hard-wired zero register index (never a hazard source)
//   DEF_REG_W     : default register-index width
//   CNT_W         : width of the stall/flush cycle counter (covers 1..7 cycles)
// ---------------------------------------------------------------------------
package hazard_pkg;

   localparam int DEF_REG_W = 5;
   localparam int CNT_W     = 3;
   localparam int REG_ZERO  = 0;

   localparam logic [1:0] ST_RUN        = 2'd0;
   localparam logic [1:0] ST_LOAD_STALL = 2'd1;
   localparam logic [1:0] ST_FLUSH      = 2'd2;
   localparam logic [1:0] ST_MEM_WAIT   = 2'd3;

   typedef enum logic [1:0] {
      RUN        = ST_RUN,
      LOAD_STALL = ST_LOAD_STALL,
      FLUSH      = ST_FLUSH,
      MEM_WAIT   = ST_MEM_WAIT
   } ctrl_state_t;

endpackage

// File: rtl/hazard_detect.sv
// ---------------------------------------------------------------------------
// hazard_detect
// Purely combinational load-use comparator. Flags a hazard when the EX-stage
// load writes a register that the ID-stage instruction actually reads.
// Register 0 is excluded because writes to it are discarded.
// Ports:
//   rs1, rs2         in  ID source register indices
//   use_rs1, use_rs2 in  ID instruction reads rs1 / rs2
//   mem_read         in  EX instruction is a load
//   rd               in  EX destination register
//   hazard           out load-use hazard present
// ---------------------------------------------------------------------------
module hazard_detect
   import hazard_pkg::*;
#(
   parameter int REG_W = DEF_REG_W
) (
   input  logic [REG_W-1:0] rs1,
   input  logic [REG_W-1:0] rs2,
   input  logic             use_rs1,
   input  logic             use_rs2,
   input  logic             mem_read,
   input  logic [REG_W-1:0] rd,
   output logic             hazard
);

   localparam logic [REG_W-1:0] RD_ZERO = REG_W'(REG_ZERO);

   logic rd_live_s;
   logic rs1_hit_s;
   logic rs2_hit_s;

   assign rd_live_s = mem_read & (rd != RD_ZERO);
   assign rs1_hit_s = use_rs1 & (rs1 == rd);
   assign rs2_hit_s = use_rs2 & (rs2 == rd);
   assign hazard    = rd_live_s & (rs1_hit_s | rs2_hit_s);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_ctrl
// Front-end sequencer for the 5-stage core: drives PC enable, IF/ID
// enable/flush and ID/EX bubble from memory stalls, taken branches and
// load-use hazards (priority in that order, evaluated in every state).
// The FSM updates on the falling clock edge, like the segment registers it
// gates; outputs are combinational from state and current inputs.
// Optional build macro: HAZARD_PERF_CNT_EN adds saturating perf counters.
// Ports:
//   clk, rst            clock (negedge active), async active-high reset
//   id_rs1/id_rs2       ID source registers, id_use_rs1/2 their read flags
//   ex_mem_read, ex_rd  EX load flag and destination register
//   ex_branch_taken     taken branch/jump resolved in EX (1-cycle pulse)
//   mem_busy            data memory not ready, freeze the front end
//   pc_en, if_id_en     PC / IF/ID write enables
//   if_id_flush         IF/ID loads NOP (overrides if_id_en)
//   id_ex_flush         ID/EX loads a bubble
//   ctrl_state          current FSM state (debug)
//   perf_stall_cnt      cycles with pc_en=0      (HAZARD_PERF_CNT_EN only)
//   perf_flush_cnt      cycles with if_id_flush=1 (HAZARD_PERF_CNT_EN only)
// ---------------------------------------------------------------------------
module pipeline_hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int LOAD_STALL_CYC = 1,
   parameter int FLUSH_CYC      = 2,
   parameter int REG_W          = DEF_REG_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [REG_W-1:0] id_rs1,
   input  logic [REG_W-1:0] id_rs2,
   input  logic             id_use_rs1,
   input  logic             id_use_rs2,
   input  logic             ex_mem_read,
   input  logic [REG_W-1:0] ex_rd,
   input  logic             ex_branch_taken,
   input  logic             mem_busy,
   output logic             pc_en,
   output logic             if_id_en,
   output logic             if_id_flush,
   output logic             id_ex_flush,
`ifdef HAZARD_PERF_CNT_EN
   output logic [31:0]      perf_stall_cnt,
   output logic [31:0]      perf_flush_cnt,
`endif
   output logic [1:0]       ctrl_state
);

   // Counter load values: remaining cycles after the one in which the event
   // is first seen (that cycle already produces the stall/flush).
   localparam logic [CNT_W-1:0] LS_INIT    = CNT_W'(LOAD_STALL_CYC - 1);
   localparam logic [CNT_W-1:0] FLUSH_INIT = CNT_W'(FLUSH_CYC - 1);
   localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [1:0]       state_r;
   logic [1:0]       state_nxt_s;
   logic [CNT_W-1:0] cnt_r;
   logic [CNT_W-1:0] cnt_nxt_s;
   logic             load_use_s;
   logic             pc_en_s;
   logic             if_id_en_s;
   logic             if_id_flush_s;
   logic             id_ex_flush_s;

   hazard_detect #(
      .REG_W    (REG_W)
   ) u_detect (
      .rs1      (id_rs1),
      .rs2      (id_rs2),
      .use_rs1  (id_use_rs1),
      .use_rs2  (id_use_rs2),
      .mem_read (ex_mem_read),
      .rd       (ex_rd),
      .hazard   (load_use_s)
   );

   // Next-state, counter and raw output decode with mem_busy > branch > load-use.
   always_comb begin
      state_nxt_s   = state_r;
      cnt_nxt_s     = cnt_r;
      pc_en_s       = 1'b1;
      if_id_en_s    = 1'b1;
      if_id_flush_s = 1'b0;
      id_ex_flush_s = 1'b0;
      if (mem_busy) begin
         // Freeze everything; counter held, state not saved.
         pc_en_s     = 1'b0;
         if_id_en_s  = 1'b0;
         state_nxt_s = ST_MEM_WAIT;
      end else if (ex_branch_taken) begin
         // Target loads into PC; wrong-path instructions are squashed.
         if_id_flush_s = 1'b1;
         id_ex_flush_s = 1'b1;
         cnt_nxt_s     = FLUSH_INIT;
         if (FLUSH_INIT != CNT_ZERO) begin
            state_nxt_s = ST_FLUSH;
         end else begin
            state_nxt_s = ST_RUN;
         end
      end else begin
         case (state_r)
            // MEM_WAIT with mem_busy low behaves as RUN this cycle, so the
            // front end restarts without an extra frozen cycle and any
            // pending counter is discarded in favour of re-evaluation.
            ST_RUN, ST_MEM_WAIT: begin
               if (load_use_s) begin
                  pc_en_s       = 1'b0;
                  if_id_en_s    = 1'b0;
                  id_ex_flush_s = 1'b1;
                  cnt_nxt_s     = LS_INIT;
                  if (LS_INIT != CNT_ZERO) begin
                     state_nxt_s = ST_LOAD_STALL;
                  end else begin
                     state_nxt_s = ST_RUN;
                  end
               end else begin
                  cnt_nxt_s   = CNT_ZERO;
                  state_nxt_s = ST_RUN;
               end
            end
            ST_LOAD_STALL: begin
               pc_en_s       = 1'b0;
               if_id_en_s    = 1'b0;
               id_ex_flush_s = 1'b1;
               cnt_nxt_s     = cnt_r - CNT_ONE;
               if (cnt_r <= CNT_ONE) begin
                  state_nxt_s = ST_RUN;
               end else begin
                  state_nxt_s = ST_LOAD_STALL;
               end
            end
            ST_FLUSH: begin
               if_id_flush_s = 1'b1;
               id_ex_flush_s = 1'b1;
               cnt_nxt_s     = cnt_r - CNT_ONE;
               if (cnt_r <= CNT_ONE) begin
                  state_nxt_s = ST_RUN;
               end else begin
                  state_nxt_s = ST_FLUSH;
               end
            end
            default: begin
               cnt_nxt_s   = CNT_ZERO;
               state_nxt_s = ST_RUN;
            end
         endcase
      end
   end

   // Reset forces the segments into a safe flushed/held condition.
   always_comb begin
      if (rst) begin
         pc_en       = 1'b0;
         if_id_en    = 1'b0;
         if_id_flush = 1'b1;
         id_ex_flush = 1'b1;
      end else begin
         pc_en       = pc_en_s;
         if_id_en    = if_id_en_s;
         if_id_flush = if_id_flush_s;
         id_ex_flush = id_ex_flush_s;
      end
   end

   assign ctrl_state = state_r;

   // FSM state and cycle counter, updated with the segment registers.
   always_ff @(negedge clk or posedge rst) begin
      if (rst) begin
         state_r <= ST_RUN;
         cnt_r   <= CNT_ZERO;
      end else begin
         state_r <= state_nxt_s;
         cnt_r   <= cnt_nxt_s;
      end
   end

`ifdef HAZARD_PERF_CNT_EN
   localparam logic [31:0] PERF_MAX = 32'hFFFF_FFFF;

   logic [31:0] perf_stall_r;
   logic [31:0] perf_flush_r;

   // Saturating counters of stalled-PC cycles and IF/ID flush cycles.
   always_ff @(negedge clk or posedge rst) begin
      if (rst) begin
         perf_stall_r <= 32'd0;
         perf_flush_r <= 32'd0;
      end else begin
         if (!pc_en && (perf_stall_r != PERF_MAX)) begin
            perf_stall_r <= perf_stall_r + 32'd1;
         end
         if (if_id_flush && (perf_flush_r != PERF_MAX)) begin
            perf_flush_r <= perf_flush_r + 32'd1;
         end
      end
   end

   assign perf_stall_cnt = perf_stall_r;
   assign perf_flush_cnt = perf_flush_r;
`else
   // Performance counters not built in this configuration.
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipeline_hazard_ctrl
// Directed bench: two controller instances share stimulus, one with a
// single-cycle load stall (a_*) and one with a three-cycle load stall (b_*),
// both with a two-cycle branch flush. Inputs change just after the rising
// edge; outputs are checked 1 time unit later, well before the falling edge
// on which the FSM advances.
// ---------------------------------------------------------------------------
module tb_pipeline_hazard_ctrl;

   logic       clk;
   logic       rst;
   logic [4:0] id_rs1;
   logic [4:0] id_rs2;
   logic       id_use_rs1;
   logic       id_use_rs2;
   logic       ex_mem_read;
   logic [4:0] ex_rd;
   logic       ex_branch_taken;
   logic       mem_busy;

   logic       a_pc_en, a_if_id_en, a_if_id_flush, a_id_ex_flush;
   logic [1:0] a_state;
   logic       b_pc_en, b_if_id_en, b_if_id_flush, b_id_ex_flush;
   logic [1:0] b_state;
`ifdef HAZARD_PERF_CNT_EN
   logic [31:0] a_perf_stall, a_perf_flush, b_perf_stall, b_perf_flush;
`endif

   int n_chk;
   int n_err;

   pipeline_hazard_ctrl #(.LOAD_STALL_CYC(1), .FLUSH_CYC(2), .REG_W(5)) dut_a (
      .clk             (clk),
      .rst             (rst),
      .id_rs1          (id_rs1),
      .id_rs2          (id_rs2),
      .id_use_rs1      (id_use_rs1),
      .id_use_rs2      (id_use_rs2),
      .ex_mem_read     (ex_mem_read),
      .ex_rd           (ex_rd),
      .ex_branch_taken (ex_branch_taken),
      .mem_busy        (mem_busy),
      .pc_en           (a_pc_en),
      .if_id_en        (a_if_id_en),
      .if_id_flush     (a_if_id_flush),
      .id_ex_flush     (a_id_ex_flush),
`ifdef HAZARD_PERF_CNT_EN
      .perf_stall_cnt  (a_perf_stall),
      .perf_flush_cnt  (a_perf_flush),
`endif
      .ctrl_state      (a_state)
   );

   pipeline_hazard_ctrl #(.LOAD_STALL_CYC(3), .FLUSH_CYC(2), .REG_W(5)) dut_b (
      .clk             (clk),
      .rst             (rst),
      .id_rs1          (id_rs1),
      .id_rs2          (id_rs2),
      .id_use_rs1      (id_use_rs1),
      .id_use_rs2      (id_use_rs2),
      .ex_mem_read     (ex_mem_read),
      .ex_rd           (ex_rd),
      .ex_branch_taken (ex_branch_taken),
      .mem_busy        (mem_busy),
      .pc_en           (b_pc_en),
      .if_id_en        (b_if_id_en),
      .if_id_flush     (b_if_id_flush),
      .id_ex_flush     (b_id_ex_flush),
`ifdef HAZARD_PERF_CNT_EN
      .perf_stall_cnt  (b_perf_stall),
      .perf_flush_cnt  (b_perf_flush),
`endif
      .ctrl_state      (b_state)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk = n_chk + 1;
      if (got !== exp) begin
         n_err = n_err + 1;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Check all four enables/flushes plus state of one instance.
   task automatic chk_a(input string tag, input logic pc, input logic en,
                        input logic ifl, input logic idx, input logic [1:0] st);
      chk({tag, ".a.pc_en"},       {31'd0, a_pc_en},       {31'd0, pc});
      chk({tag, ".a.if_id_en"},    {31'd0, a_if_id_en},    {31'd0, en});
      chk({tag, ".a.if_id_flush"}, {31'd0, a_if_id_flush}, {31'd0, ifl});
      chk({tag, ".a.id_ex_flush"}, {31'd0, a_id_ex_flush}, {31'd0, idx});
      chk({tag, ".a.state"},       {30'd0, a_state},       {30'd0, st});
   endtask

   task automatic chk_b(input string tag, input logic pc, input logic en,
                        input logic ifl, input logic idx, input logic [1:0] st);
      chk({tag, ".b.pc_en"},       {31'd0, b_pc_en},       {31'd0, pc});
      chk({tag, ".b.if_id_en"},    {31'd0, b_if_id_en},    {31'd0, en});
      chk({tag, ".b.if_id_flush"}, {31'd0, b_if_id_flush}, {31'd0, ifl});
      chk({tag, ".b.id_ex_flush"}, {31'd0, b_id_ex_flush}, {31'd0, idx});
      chk({tag, ".b.state"},       {30'd0, b_state},       {30'd0, st});
   endtask

   // One cycle: apply inputs after the rising edge, settle, then checks follow.
   task automatic step(input logic mr, input logic [4:0] rd, input logic [4:0] r1,
                       input logic u1, input logic [4:0] r2, input logic u2,
                       input logic br, input logic mb);
      @(posedge clk);
      ex_mem_read     = mr;
      ex_rd           = rd;
      id_rs1          = r1;
      id_use_rs1      = u1;
      id_rs2          = r2;
      id_use_rs2      = u2;
      ex_branch_taken = br;
      mem_busy        = mb;
      #1;
   endtask

   task automatic idle();
      step(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic hazard5();
      step(1'b1, 5'd5, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      n_chk = 0;
      n_err = 0;
      rst = 1'b1;
      ex_mem_read = 1'b0; ex_rd = 5'd0; id_rs1 = 5'd0; id_rs2 = 5'd0;
      id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; ex_branch_taken = 1'b0; mem_busy = 1'b0;
      #2;
      chk_a("reset", 1'b0, 1'b0, 1'b1, 1'b1, 2'd0);
`ifdef HAZARD_PERF_CNT_EN
      chk("reset.perf_stall", a_perf_stall, 32'd0);
      chk("reset.perf_flush", a_perf_flush, 32'd0);
`endif
      @(posedge clk);
      @(posedge clk);
      rst = 1'b0;

      // Idle pipeline runs freely.
      idle();
      chk_a("idle", 1'b1, 1'b1, 1'b0, 1'b0, 2'd0);

      // Load-use on rs1: one bubble (a), three bubbles (b).
      hazard5();
      chk_a("lu1.c0", 1'b0, 1'b0, 1'b0, 1'b1, 2'd0);
      chk_b("lu1.c0", 1'b0, 1'b0, 1'b0, 1'b1, 2'd0);
      idle();
      chk_a("lu1.c1", 1'b1, 1'b1, 1'b0, 1'b0, 2'd0);
      chk_b("lu3.c1", 1'b0, 1'b0, 1'b0, 1'b1, 2'd1);
      idle();
      chk_b("lu3.c2", 1'b0, 1'b0, 1'b0, 1'b1, 2'd1);
      idle();
      chk_b("lu3.c3", 1'b1, 1'b1, 1'b0, 1'b0, 2'd0);

      // No hazard: rd is x0, or rs1 not actually read.
      step(1'b1, 5'd0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
      chk_a("rd0", 1'b1, 1'b1, 1'b0, 1'b0, 2'd0);
      step(1'b1, 5'd5, 5'd5, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
      chk_a("nouse", 1'b1, 1'b1, 1'b0, 1'b0, 2'd0);
      // Non-load writing the same register is not a load-use hazard.
      step(1'b0, 5'd5, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
      chk_a("noload", 1'b1, 1'b1, 1'b0, 1'b0, 2'd0);

      // Hazard through rs2.
      step(1'b1, 5'd7, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0);
      chk_a("rs2", 1'b0, 1'b0, 1'b0, 1'b1, 2'd0);
      idle();
      chk_a("rs2.c1", 1'b1, 1'b1, 1'b0, 1'b0, 2'd0);
      idle();
      idle();
      chk_b("rs2.done", 1'b1, 1'b1, 1'b0, 1'b0, 2'd0);

      // Taken branch: two flush cycles, PC keeps loading.
      step(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
      chk_a("br.c0", 1'b1, 1'b1, 1'b1, 1'b1, 2'd0);
      idle();
      chk_a("br.c1", 1'b1, 1'b1, 1'b1, 1'b1, 2'd2);
      idle();
      chk_a("br.c2", 1'b1, 1'b1, 1'b0, 1'b0, 2'd0);

      // mem_busy for 4 cycles during FLUSH: frozen, then RUN without flush.
      step(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
      step(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
      chk_a("mb.c0", 1'b0, 1'b0, 1'b0, 1'b0, 2'd2);
      for (int i = 1; i < 4; i++) begin
         step(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
         chk_a("mb.cn", 1'b0, 1'b0, 1'b0, 1'b0, 2'd3);
      end
      idle();
      chk_a("mb.rel", 1'b1, 1'b1, 1'b0, 1'b0, 2'd3);
      idle();
      chk_a("mb.run", 1'b1, 1'b1, 1'b0, 1'b0, 2'd0);

      // Load-use and branch together: branch wins.
      step(1'b1, 5'd5, 5'd5, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0);
      chk_a("lu+br", 1'b1, 1'b1, 1'b1, 1'b1, 2'd0);
      idle();
      chk_a("lu+br.c1", 1'b1, 1'b1, 1'b1, 1'b1, 2'd2);
      chk_b("lu+br.c1", 1'b1, 1'b1, 1'b1, 1'b1, 2'd2);
      idle();
      chk_b("lu+br.c2", 1'b1, 1'b1, 1'b0, 1'b0, 2'd0);

      // Branch arriving during LOAD_STALL (b): enters FLUSH.
      hazard5();
      step(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
      chk_b("ls+br", 1'b1, 1'b1, 1'b1, 1'b1, 2'd1);
      idle();
      chk_b("ls+br.c1", 1'b1, 1'b1, 1'b1, 1'b1, 2'd2);
      idle();
      chk_b("ls+br.c2", 1'b1, 1'b1, 1'b0, 1'b0, 2'd0);

      // Reset in the middle of a 3-cycle load stall.
      hazard5();
      idle();
      chk_b("pre.rst", 1'b0, 1'b0, 1'b0, 1'b1, 2'd1);
      @(posedge clk);
      rst = 1'b1;
      #1;
      chk_b("mid.rst", 1'b0, 1'b0, 1'b1, 1'b1, 2'd0);
`ifdef HAZARD_PERF_CNT_EN
      chk("mid.rst.perf_stall", b_perf_stall, 32'd0);
      chk("mid.rst.perf_flush", b_perf_flush, 32'd0);
`endif
      @(posedge clk);
      rst = 1'b0;
      #1;
      chk_b("post.rst", 1'b1, 1'b1, 1'b0, 1'b0, 2'd0);
`ifdef HAZARD_PERF_CNT_EN
      chk("post.rst.perf_stall", b_perf_stall, 32'd0);
      // One stalled cycle is counted on the next falling edge.
      hazard5();
      @(negedge clk);
      #1;
      chk("perf.stall1", a_perf_stall, 32'd1);
`endif

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
